// File: rtl/mem_stage_if.sv
// Shared execute/memory record types and the mem_stage bus bundle.
// The misalign signal exists only when MEM_MISALIGN_TRAP_EN is defined.
package mem_pkg;
    typedef struct packed {
        logic memread;
        logic memwrite;
    } ctl_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] raw_instr;
    } pc_instr_t;

    typedef struct packed {
        logic [63:0] aluout;
        logic [63:0] memwrite_data;
        ctl_t        ctl;
        pc_instr_t   pc_instr;
        logic [4:0]  dst;
    } execute_data_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [4:0]  dst;
        pc_instr_t   pc_instr;
        logic [63:0] result;
    } memory_data_t;
endpackage

interface mem_stage_if #(parameter int AW = 64) ();
    import mem_pkg::*;

    execute_data_t dataE;
    logic          valid_in;
    logic          dreq_valid;
    logic [AW-1:0] dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    memory_data_t  dataM;
    logic          valid_out;
    logic          busy;
`ifdef MEM_MISALIGN_TRAP_EN
    logic          misalign;
`endif

    modport master (
        input  dataE, valid_in, dresp_data_ok, dresp_data,
        output dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        output dataM, valid_out, busy
`ifdef MEM_MISALIGN_TRAP_EN
        , output misalign
`endif
    );

    modport slave (
        output dataE, valid_in, dresp_data_ok, dresp_data,
        input  dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
        input  dataM, valid_out, busy
`ifdef MEM_MISALIGN_TRAP_EN
        , input misalign
`endif
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on the data bus and formats results for writeback.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned accesses into a one-cycle misalign exception.
//   state | meaning
//   IDLE  | accepting dataE; ALU ops and traps complete here in one cycle
//   REQ   | bus request held stable until dresp_data_ok
//   RESP  | valid_out pulse with load/store result
module mem_stage #(
    parameter int AW = 64
) (
    input logic   clk,
    input logic   reset,
    mem_stage_if.master bus
);
    import mem_pkg::*;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;
    state_t state, nextState;

    ctl_t          opCtl;
    logic [4:0]    opDst;
    pc_instr_t     opPcInstr;
    logic [63:0]   opAlu;
    logic [AW-1:0] reqAddr;
    logic [1:0]    reqSize;
    logic [7:0]    reqStrobe;
    logic [63:0]   reqData;
    memory_data_t  dataMReg;
    logic          validOutReg;
    logic          busyComb;
    logic          dreqValidComb;

    logic          isMemOp;
    logic          misTrap;
    logic [2:0]    offE;
    logic [1:0]    sizeE;
    logic [7:0]    sizeBase;
    logic [7:0]    strobeE;
    logic [63:0]   loadShift;
    logic [63:0]   loadResult;

    assign isMemOp = bus.dataE.ctl.memread | bus.dataE.ctl.memwrite;
    assign offE    = bus.dataE.aluout[2:0];
    assign sizeE   = bus.dataE.pc_instr.raw_instr[13:12];

    always_comb begin
        sizeBase = 8'hFF;
        case (sizeE)
            2'd0:    sizeBase = 8'h01;
            2'd1:    sizeBase = 8'h03;
            2'd2:    sizeBase = 8'h0F;
            default: sizeBase = 8'hFF;
        endcase
    end

    // Shift in 8 bits so lanes past the doubleword boundary fall off.
    assign strobeE = sizeBase << offE;

`ifdef MEM_MISALIGN_TRAP_EN
    logic [2:0] alignMask;
    logic       misalignReg;
    assign alignMask = 3'((4'd1 << sizeE) - 4'd1);
    assign misTrap   = isMemOp && ((offE & alignMask) != 3'd0);
`else
    assign misTrap = 1'b0;
`endif

    assign loadShift = bus.dresp_data >> {opAlu[2:0], 3'b000};

    always_comb begin
        loadResult = loadShift;
        case (opPcInstr.raw_instr[14:12])
            3'b000:  loadResult = {{56{loadShift[7]}},  loadShift[7:0]};
            3'b001:  loadResult = {{48{loadShift[15]}}, loadShift[15:0]};
            3'b010:  loadResult = {{32{loadShift[31]}}, loadShift[31:0]};
            3'b100:  loadResult = {56'd0, loadShift[7:0]};
            3'b101:  loadResult = {48'd0, loadShift[15:0]};
            3'b110:  loadResult = {32'd0, loadShift[31:0]};
            default: loadResult = loadShift;
        endcase
    end

    always_comb begin
        nextState     = state;
        busyComb      = 1'b0;
        dreqValidComb = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_in && isMemOp && !misTrap && !reset) begin
                    nextState = REQ;
                    busyComb  = 1'b1;
                end
            end
            REQ: begin
                busyComb      = 1'b1;
                dreqValidComb = 1'b1;
                if (bus.dresp_data_ok) nextState = RESP;
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opCtl       <= '0;
            opDst       <= '0;
            opPcInstr   <= '0;
            opAlu       <= '0;
            reqAddr     <= '0;
            reqSize     <= '0;
            reqStrobe   <= '0;
            reqData     <= '0;
            dataMReg    <= '0;
            validOutReg <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalignReg <= 1'b0;
`endif
        end else begin
            validOutReg <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalignReg <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        if (isMemOp && !misTrap) begin
                            opCtl     <= bus.dataE.ctl;
                            opDst     <= bus.dataE.dst;
                            opPcInstr <= bus.dataE.pc_instr;
                            opAlu     <= bus.dataE.aluout;
                            reqAddr   <= bus.dataE.aluout[AW-1:0];
                            reqSize   <= sizeE;
                            reqStrobe <= bus.dataE.ctl.memwrite ? strobeE : 8'h00;
                            reqData   <= bus.dataE.memwrite_data << {offE, 3'b000};
                        end else begin
                            dataMReg.ctl      <= bus.dataE.ctl;
                            dataMReg.dst      <= bus.dataE.dst;
                            dataMReg.pc_instr <= bus.dataE.pc_instr;
                            dataMReg.result   <= bus.dataE.aluout;
                            validOutReg       <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                            misalignReg       <= misTrap;
`endif
                        end
                    end
                end
                REQ: begin
                    if (bus.dresp_data_ok) begin
                        dataMReg.ctl      <= opCtl;
                        dataMReg.dst      <= opDst;
                        dataMReg.pc_instr <= opPcInstr;
                        dataMReg.result   <= opCtl.memwrite ? opAlu : loadResult;
                        validOutReg       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.dreq_valid  = dreqValidComb;
    assign bus.dreq_addr   = reqAddr;
    assign bus.dreq_size   = {1'b0, reqSize};
    assign bus.dreq_strobe = reqStrobe;
    assign bus.dreq_data   = reqData;
    assign bus.dataM       = dataMReg;
    assign bus.valid_out   = validOutReg;
    assign bus.busy        = busyComb;
`ifdef MEM_MISALIGN_TRAP_EN
    assign bus.misalign    = misalignReg;
`endif
endmodule
